// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: merges the core's instruction and data memory request
// streams onto one memory port with round-robin arbitration. A small FIFO of
// 1-bit source tags records the issue order, so in-order memory responses
// can be steered back to the right requester.
//
// Handshake: a transfer happens on a rising edge where val & rdy are both 1.
// Once asserted, memreq_val is held with its message stable until memreq_rdy.
// Responses have no backpressure: a response is consumed in the same cycle
// that memresp_val is high.
module riscv_mem_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] imemreq_msg,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  output logic [34:0] imemresp_msg,
  output logic        imemresp_val,
  input  logic [66:0] dmemreq_msg,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  output logic [34:0] dmemresp_msg,
  output logic        dmemresp_val,
  output logic [66:0] memreq_msg,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic [34:0] memresp_msg,
  input  logic        memresp_val,
  output logic [4:0]  outstanding,
  output logic        err_orphan
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [4:0]      FULL_CNT = 5'(DEPTH);

  // Tag FIFO: bit value 0 = imem, 1 = dmem.
  logic [DEPTH-1:0] r_tags;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [4:0]       r_count;
  // Round-robin pointer: 1 when dmem was granted most recently.
  logic             r_last_dmem;
  // Grant lock while a request is stalled by memreq_rdy = 0.
  logic             r_hold;
  logic             r_hold_dmem;
  logic             r_err;

  logic w_full;
  logic w_empty;
  logic w_sel_dmem;
  logic w_sel_val;
  logic w_fire;
  logic w_pop;
  logic w_orphan;
  logic w_head;

  // Grant selection and request-side handshake.
  always_comb begin
    w_full  = (r_count == FULL_CNT);
    w_empty = (r_count == 5'd0);
    if (r_hold) begin
      w_sel_dmem = r_hold_dmem;
    end else if (imemreq_val && dmemreq_val) begin
      w_sel_dmem = ~r_last_dmem;
    end else begin
      w_sel_dmem = dmemreq_val;
    end
    w_sel_val   = w_sel_dmem ? dmemreq_val : imemreq_val;
    memreq_msg  = w_sel_dmem ? dmemreq_msg : imemreq_msg;
    memreq_val  = reset & ~w_full & w_sel_val;
    imemreq_rdy = reset & ~w_full & ~w_sel_dmem & memreq_rdy;
    dmemreq_rdy = reset & ~w_full &  w_sel_dmem & memreq_rdy;
    w_fire      = memreq_val & memreq_rdy;
  end

  // Response steering by the tag at the FIFO head.
  always_comb begin
    w_head       = r_tags[r_rptr];
    w_pop        = reset & memresp_val & ~w_empty;
    w_orphan     = reset & memresp_val &  w_empty;
    imemresp_msg = memresp_msg;
    dmemresp_msg = memresp_msg;
    imemresp_val = w_pop & ~w_head;
    dmemresp_val = w_pop &  w_head;
    outstanding  = r_count;
    err_orphan   = r_err;
  end

  // FIFO pointers, occupancy, arbitration state and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tags      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= 5'd0;
      r_last_dmem <= 1'b0;
      r_hold      <= 1'b0;
      r_hold_dmem <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_hold      <= memreq_val & ~memreq_rdy;
      r_hold_dmem <= w_sel_dmem;
      if (w_fire) begin
        r_tags[r_wptr] <= w_sel_dmem;
        r_wptr         <= r_wptr + PTR_ONE;
        r_last_dmem    <= w_sel_dmem;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count <= r_count + {4'd0, w_fire} - {4'd0, w_pop};
      if (w_orphan) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: inputs change 1 time unit after the
// rising edge, combinational outputs are observed on the falling edge and
// registered outputs 1 time unit after the rising edge.
module tb_riscv_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [66:0] imemreq_msg;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [34:0] imemresp_msg;
  logic        imemresp_val;
  logic [66:0] dmemreq_msg;
  logic        dmemreq_val;
  logic        dmemreq_rdy;
  logic [34:0] dmemresp_msg;
  logic        dmemresp_val;
  logic [66:0] memreq_msg;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [34:0] memresp_msg;
  logic        memresp_val;
  logic [4:0]  outstanding;
  logic        err_orphan;

  int n_vec = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  riscv_mem_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // VC mem req: type(1) addr(32) len(2) data(32); resp: type(1) len(2) data(32)
  function automatic logic [66:0] mk_req(input logic [31:0] addr, input logic [31:0] data);
    return {1'b0, addr, 2'b00, data};
  endfunction

  function automatic logic [34:0] mk_resp(input logic [31:0] data);
    return {1'b0, 2'b00, data};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imemreq_val = 1'b0;
    dmemreq_val = 1'b0;
    memresp_val = 1'b0;
    memreq_rdy  = 1'b1;
  endtask

  // Consume one response and check it lands on the expected side.
  task automatic drain_one(input logic exp_d, input logic [31:0] data, input string name);
    memresp_msg = mk_resp(data);
    memresp_val = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dmemresp_val !== exp_d || imemresp_val !== !exp_d ||
        (exp_d ? dmemresp_msg : imemresp_msg) !== mk_resp(data)) begin
      n_err++;
      $display("FAIL %s: imem_val=%b dmem_val=%b data=%h, required dmem_val=%b data=%h",
               name, imemresp_val, dmemresp_val, exp_d ? dmemresp_msg[31:0] : imemresp_msg[31:0],
               exp_d, data);
    end
    next_cycle();
    memresp_val = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    imemreq_msg = mk_req(32'h100, 32'h0);
    dmemreq_msg = mk_req(32'h2000, 32'h0);
    imemreq_val = 1'b1;
    dmemreq_val = 1'b1;
    memreq_rdy  = 1'b1;
    memresp_msg = mk_resp(32'h0);
    memresp_val = 1'b1;
    next_cycle();
    @(negedge clk);
    n_vec++;
    if ({imemreq_rdy, dmemreq_rdy, memreq_val, imemresp_val, dmemresp_val} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy/val bits=%b, required 00000",
               {imemreq_rdy, dmemreq_rdy, memreq_val, imemresp_val, dmemresp_val});
    end
    n_vec++;
    if (outstanding !== 5'd0 || err_orphan !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: outstanding=%0d err=%b, required 0 0", outstanding, err_orphan);
    end
    next_cycle();
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_d;
    logic [66:0] imsg;
    logic [66:0] dmsg;
    imsg = mk_req(32'h100, 32'h0);
    dmsg = mk_req(32'h2000, 32'hCAFE);
    imemreq_msg = imsg;
    dmemreq_msg = dmsg;
    imemreq_val = 1'b1;
    dmemreq_val = 1'b1;
    memreq_rdy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      @(negedge clk);
      n_vec++;
      if (dmemreq_rdy !== exp_d || imemreq_rdy !== !exp_d || memreq_val !== 1'b1 ||
          memreq_msg !== (exp_d ? dmsg : imsg)) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: dmem_rdy=%b imem_rdy=%b val=%b, required dmem_rdy=%b",
                 k, dmemreq_rdy, imemreq_rdy, memreq_val, exp_d);
      end
      next_cycle();
      n_vec++;
      if (outstanding !== 5'(k + 1)) begin
        n_err++;
        $display("FAIL rr_outstanding[%0d]: got %0d, required %0d", k, outstanding, k + 1);
      end
    end
    // Full: nothing may be issued even with memreq_rdy = 1.
    @(negedge clk);
    n_vec++;
    if (imemreq_rdy !== 1'b0 || dmemreq_rdy !== 1'b0 || memreq_val !== 1'b0) begin
      n_err++;
      $display("FAIL full_block: imem_rdy=%b dmem_rdy=%b val=%b, required 0 0 0",
               imemreq_rdy, dmemreq_rdy, memreq_val);
    end
    next_cycle();
    // First response goes to the first issuer (dmem); still no issue this cycle.
    memresp_msg = mk_resp(32'h55);
    memresp_val = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dmemresp_val !== 1'b1 || imemresp_val !== 1'b0 || dmemresp_msg !== mk_resp(32'h55) ||
        memreq_val !== 1'b0) begin
      n_err++;
      $display("FAIL full_pop: imem_val=%b dmem_val=%b data=%h req_val=%b, required 0 1 55 0",
               imemresp_val, dmemresp_val, dmemresp_msg[31:0], memreq_val);
    end
    next_cycle();
    memresp_val = 1'b0;
    n_vec++;
    if (outstanding !== 5'd3) begin
      n_err++;
      $display("FAIL full_pop_count: got %0d, required 3", outstanding);
    end
    @(negedge clk);
    n_vec++;
    if (dmemreq_rdy !== 1'b1 || imemreq_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL rdy_restored: imem_rdy=%b dmem_rdy=%b, required 0 1", imemreq_rdy, dmemreq_rdy);
    end
    imemreq_val = 1'b0;
    dmemreq_val = 1'b0;
    next_cycle();
    drain_one(1'b0, 32'h61, "rr_drain0");
    drain_one(1'b1, 32'h62, "rr_drain1");
    drain_one(1'b0, 32'h63, "rr_drain2");
    n_vec++;
    if (outstanding !== 5'd0) begin
      n_err++;
      $display("FAIL rr_empty: got %0d, required 0", outstanding);
    end
  endtask

  task automatic test_ordering();
    imemreq_msg = mk_req(32'h100, 32'h0);
    dmemreq_msg = mk_req(32'h2000, 32'h0);
    imemreq_val = 1'b1;
    @(negedge clk);
    n_vec++;
    if (imemreq_rdy !== 1'b1 || memreq_msg !== mk_req(32'h100, 32'h0)) begin
      n_err++;
      $display("FAIL order_issue_a: imem_rdy=%b addr=%h, required 1 00000100", imemreq_rdy, memreq_msg[65:34]);
    end
    next_cycle();
    imemreq_val = 1'b0;
    dmemreq_val = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dmemreq_rdy !== 1'b1 || memreq_msg !== mk_req(32'h2000, 32'h0)) begin
      n_err++;
      $display("FAIL order_issue_b: dmem_rdy=%b addr=%h, required 1 00002000", dmemreq_rdy, memreq_msg[65:34]);
    end
    next_cycle();
    dmemreq_val = 1'b0;
    drain_one(1'b0, 32'h11, "order_resp_a");
    drain_one(1'b1, 32'h22, "order_resp_b");
  endtask

  task automatic test_back_to_back();
    logic src;
    logic exp_d;
    exp_q.delete();
    imemreq_msg = mk_req(32'h300, 32'h0);
    dmemreq_msg = mk_req(32'h4000, 32'h0);
    imemreq_val = 1'b1;
    next_cycle();
    exp_q.push_back(1'b0);
    imemreq_val = 1'b0;
    dmemreq_val = 1'b1;
    next_cycle();
    exp_q.push_back(1'b1);
    dmemreq_val = 1'b0;
    n_vec++;
    if (outstanding !== 5'd2) begin
      n_err++;
      $display("FAIL b2b_prefill: got %0d, required 2", outstanding);
    end
    for (int k = 0; k < 20; k++) begin
      src = (k % 3 == 0);
      imemreq_val = !src;
      dmemreq_val = src;
      memresp_msg = mk_resp(32'h1000 + 32'(k));
      memresp_val = 1'b1;
      exp_d = exp_q[0];
      @(negedge clk);
      n_vec++;
      if (dmemresp_val !== exp_d || imemresp_val !== !exp_d ||
          (src ? dmemreq_rdy : imemreq_rdy) !== 1'b1) begin
        n_err++;
        $display("FAIL b2b[%0d]: imem_val=%b dmem_val=%b src_rdy=%b, required dmem_val=%b rdy=1",
                 k, imemresp_val, dmemresp_val, src ? dmemreq_rdy : imemreq_rdy, exp_d);
      end
      next_cycle();
      void'(exp_q.pop_front());
      exp_q.push_back(src);
      n_vec++;
      if (outstanding !== 5'd2) begin
        n_err++;
        $display("FAIL b2b_count[%0d]: got %0d, required 2", k, outstanding);
      end
    end
    idle_inputs();
    drain_one(exp_q[0], 32'h77, "b2b_tail0");
    void'(exp_q.pop_front());
    drain_one(exp_q[0], 32'h78, "b2b_tail1");
    void'(exp_q.pop_front());
  endtask

  task automatic test_orphan();
    memresp_msg = mk_resp(32'hBAD);
    memresp_val = 1'b1;
    @(negedge clk);
    n_vec++;
    if (imemresp_val !== 1'b0 || dmemresp_val !== 1'b0) begin
      n_err++;
      $display("FAIL orphan_drop: imem_val=%b dmem_val=%b, required 0 0", imemresp_val, dmemresp_val);
    end
    next_cycle();
    memresp_val = 1'b0;
    n_vec++;
    if (err_orphan !== 1'b1) begin
      n_err++;
      $display("FAIL orphan_set: err=%b, required 1", err_orphan);
    end
    imemreq_val = 1'b1;
    repeat (3) next_cycle();
    imemreq_val = 1'b0;
    n_vec++;
    if (err_orphan !== 1'b1 || outstanding !== 5'd3) begin
      n_err++;
      $display("FAIL orphan_sticky: err=%b outstanding=%0d, required 1 3", err_orphan, outstanding);
    end
    reset = 1'b0;
    imemreq_val = 1'b1;
    memresp_val = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({imemreq_rdy, memreq_val, imemresp_val, dmemresp_val} !== 4'b0) begin
      n_err++;
      $display("FAIL midreset_gate: bits=%b, required 0000",
               {imemreq_rdy, memreq_val, imemresp_val, dmemresp_val});
    end
    next_cycle();
    n_vec++;
    if (outstanding !== 5'd0 || err_orphan !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: outstanding=%0d err=%b, required 0 0", outstanding, err_orphan);
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [66:0] dmsg;
    logic [66:0] imsg;
    dmsg = mk_req(32'h2040, 32'hABCD);
    imsg = mk_req(32'h140, 32'h0);
    dmemreq_msg = dmsg;
    imemreq_msg = imsg;
    // One dmem fire so a later tie would favour imem.
    dmemreq_val = 1'b1;
    next_cycle();
    memreq_rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) imemreq_val = 1'b1;
      @(negedge clk);
      n_vec++;
      if (memreq_val !== 1'b1 || memreq_msg !== dmsg || dmemreq_rdy !== 1'b0 || imemreq_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: val=%b addr=%h imem_rdy=%b dmem_rdy=%b, required 1 00002040 0 0",
                 s, memreq_val, memreq_msg[65:34], imemreq_rdy, dmemreq_rdy);
      end
      next_cycle();
    end
    memreq_rdy = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dmemreq_rdy !== 1'b1 || imemreq_rdy !== 1'b0 || memreq_msg !== dmsg) begin
      n_err++;
      $display("FAIL stall_release: imem_rdy=%b dmem_rdy=%b addr=%h, required 0 1 00002040",
               imemreq_rdy, dmemreq_rdy, memreq_msg[65:34]);
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if (imemreq_rdy !== 1'b1 || dmemreq_rdy !== 1'b0 || memreq_msg !== imsg) begin
      n_err++;
      $display("FAIL stall_next_rr: imem_rdy=%b dmem_rdy=%b, required 1 0", imemreq_rdy, dmemreq_rdy);
    end
    next_cycle();
    idle_inputs();
    n_vec++;
    if (outstanding !== 5'd3) begin
      n_err++;
      $display("FAIL stall_count: got %0d, required 3", outstanding);
    end
    drain_one(1'b1, 32'h91, "stall_drain0");
    drain_one(1'b1, 32'h92, "stall_drain1");
    drain_one(1'b0, 32'h93, "stall_drain2");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_ordering();
    test_back_to_back();
    test_orphan();
    test_stall();
    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
